// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Prefetching instruction fetch stage. It owns the fetch address and issues
//   word reads to the instruction cache, with at most one read in flight.
//   Returned words are queued together with their addresses, and the control
//   unit pops them when it loads IR. A flush redirects fetch and empties the
//   queue. A read that is still in flight at the flush is discarded when its
//   ack arrives.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_req/mem_addr  read request pulse and its word address (combinational)
//   mem_ack/mem_data  read completion pulse and its instruction word
//   inst_valid        queue not empty
//   inst/inst_addr    head instruction and its address
//   inst_take         pop the head (ignored while the queue is empty)
//   flush/flush_addr  redirect fetch to flush_addr, empty the queue
//   count             queue occupancy
//
// Read tracking (outstanding, discard)
//   state | meaning
//   IDLE  | (0,0) no read in flight
//   WAIT  | (1,0) read in flight, its data will be queued
//   DRAIN | (1,1) read in flight from before a flush, its data is dropped
module inst_fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_data,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_addr,
  input  logic                     inst_take,
  input  logic                     flush,
  input  logic [31:0]              flush_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          outstanding;
  logic          discard;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   addr_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic          ack_live;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic          issue;

  // An ack with nothing in flight is a protocol error and is ignored.
  assign ack_live = mem_ack && outstanding;
  assign push     = ack_live && !discard;
  assign pop      = inst_take && (count_q != '0);

  // The occupancy used for the issue decision counts the read in flight
  // (whether or not it lands this cycle) and credits a same-cycle pop. This
  // reserves a slot for every issued read, so a push never meets a full queue.
  assign occ = {1'b0, count_q} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};

  // DRAIN blocks issue even in the stale-ack cycle. The first post-flush read
  // goes out the cycle after that ack.
  assign issue = rst_n && !flush && !discard && (!outstanding || mem_ack)
                 && (occ < DEPTH_W);

  assign mem_req    = issue;
  assign mem_addr   = fetch_pc;
  assign count      = count_q;
  assign inst_valid = (count_q != '0);
  assign inst       = data_q[rd_ptr];
  assign inst_addr  = addr_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_ADDR;
      req_addr    <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      fetch_pc <= flush_addr;
      // A read that is not acked this cycle must have its data dropped later.
      // A same-cycle ack is dropped here.
      outstanding <= outstanding && !mem_ack;
      discard     <= outstanding && !mem_ack;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= mem_data;
        addr_q[wr_ptr] <= req_addr;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (ack_live) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      // A reissue in the ack cycle overrides the clear above.
      if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd1;
      end
    end
  end

endmodule
